// File: rtl/phase_accum_sequencer_pkg.sv
// Shared constants and FSM state type for the phase accumulator sequencer.
// Optional hard-sync support is selected with PHASE_HARD_SYNC_EN.
package synth_pkg;
  localparam int NVOICE      = 16;
  localparam int VOICE_IDX_W = 4;
  localparam int ACC_W_DEF   = 52;
  localparam int OUT_W_DEF   = 16;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    RD,
    WR
  } seq_state_e;
endpackage

// File: rtl/phase_accum_sequencer_if.sv
// Host/control and phase-output bundle of the sequencer.
// sync_req exists only when PHASE_HARD_SYNC_EN is defined.
interface phase_accum_sequencer_if
  import synth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
);
  logic                   sample_tick;
  logic                   inc_we;
  logic [VOICE_IDX_W-1:0] inc_addr;
  logic [ACC_W-1:0]       inc_data;
`ifdef PHASE_HARD_SYNC_EN
  logic [NVOICE-1:0]      sync_req;
`endif
  logic [OUT_W-1:0]       phase_out;
  logic [VOICE_IDX_W-1:0] phase_voice;
  logic                   phase_valid;
  logic                   phase_wrap;
  logic                   sweep_done;
  logic                   busy;
  logic                   overrun;

  modport master (
    output sample_tick, inc_we, inc_addr, inc_data,
`ifdef PHASE_HARD_SYNC_EN
    output sync_req,
`endif
    input  phase_out, phase_voice, phase_valid, phase_wrap,
    input  sweep_done, busy, overrun
  );

  modport slave (
    input  sample_tick, inc_we, inc_addr, inc_data,
`ifdef PHASE_HARD_SYNC_EN
    input  sync_req,
`endif
    output phase_out, phase_voice, phase_valid, phase_wrap,
    output sweep_done, busy, overrun
  );
endinterface

// File: rtl/phase_accum_sequencer_phase_store.sv
// 16-entry phase store: asynchronous read, synchronous write, no reset,
// so it maps onto distributed RAM.
module phase_store
  import synth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [VOICE_IDX_W-1:0] i_addr,
  input  logic [ACC_W-1:0]       i_wdata,
  output logic [ACC_W-1:0]       o_rdata
);
  logic [ACC_W-1:0] r_mem [NVOICE];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/phase_accum_sequencer.sv
// Time-multiplexed 16-voice phase accumulator: RD/WR sweep over the phase
// store on each sample tick. Optional per-voice hard sync: PHASE_HARD_SYNC_EN.
module phase_accum_sequencer
  import synth_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  phase_accum_sequencer_if.slave bus
);
  localparam logic [VOICE_IDX_W-1:0] LAST_V = VOICE_IDX_W'(NVOICE - 1);

  seq_state_e             r_state, w_state_nxt;
  logic [VOICE_IDX_W-1:0] r_voice, w_voice_nxt;
  logic                   r_pending, w_pending_nxt;
  logic                   w_overrun, w_out_ld, w_done;

  logic [ACC_W-1:0]       r_inc [NVOICE];
  logic [ACC_W-1:0]       r_ph_lat, r_inc_lat;
  logic [ACC_W:0]         w_sum;
  logic [ACC_W-1:0]       w_upd_phase;
  logic                   w_upd_wrap;

  logic                   w_st_we;
  logic [ACC_W-1:0]       w_st_wdata, w_st_rdata;

  logic [OUT_W-1:0]       r_phase_out;
  logic [VOICE_IDX_W-1:0] r_phase_voice;
  logic                   r_phase_valid, r_phase_wrap, r_sweep_done, r_overrun;

  phase_store #(.ACC_W(ACC_W)) u_store (
    .clk     (clk),
    .i_we    (w_st_we),
    .i_addr  (r_voice),
    .i_wdata (w_st_wdata),
    .o_rdata (w_st_rdata)
  );

  assign w_sum = {1'b0, r_ph_lat} + {1'b0, r_inc_lat};

`ifdef PHASE_HARD_SYNC_EN
  logic [NVOICE-1:0] r_sync, w_sync_clr;
  logic              w_sync_hit;

  assign w_sync_hit  = r_sync[r_voice];
  assign w_sync_clr  = (r_state == WR) ? ({{(NVOICE-1){1'b0}}, 1'b1} << r_voice) : '0;
  // A synced voice restarts from zero and takes one step, so it never wraps.
  assign w_upd_phase = w_sync_hit ? r_inc_lat : w_sum[ACC_W-1:0];
  assign w_upd_wrap  = w_sync_hit ? 1'b0 : w_sum[ACC_W];

  // A request arriving during its own voice's WR survives for the next sweep.
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= (r_sync & ~w_sync_clr) | bus.sync_req;
  end
`else
  assign w_upd_phase = w_sum[ACC_W-1:0];
  assign w_upd_wrap  = w_sum[ACC_W];
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_voice_nxt   = r_voice;
    w_pending_nxt = r_pending;
    w_overrun     = 1'b0;
    w_out_ld      = 1'b0;
    w_done        = 1'b0;
    w_st_we       = 1'b0;
    w_st_wdata    = '0;

    // Ticks outside IDLE queue one deep; any further tick is dropped.
    if (bus.sample_tick && r_state != IDLE) begin
      if (r_pending) w_overrun     = 1'b1;
      else           w_pending_nxt = 1'b1;
    end

    case (r_state)
      CLEAR: begin
        w_st_we = 1'b1;
        if (r_voice == LAST_V) begin
          w_state_nxt = IDLE;
          w_voice_nxt = '0;
        end else begin
          w_voice_nxt = r_voice + 1'b1;
        end
      end
      IDLE: begin
        if (bus.sample_tick || r_pending) begin
          w_state_nxt   = RD;
          w_voice_nxt   = '0;
          w_pending_nxt = 1'b0;
        end
      end
      RD: w_state_nxt = WR;
      WR: begin
        w_st_we    = 1'b1;
        w_st_wdata = w_upd_phase;
        w_out_ld   = 1'b1;
        if (r_voice == LAST_V) begin
          w_state_nxt = IDLE;
          w_voice_nxt = '0;
          w_done      = 1'b1;
        end else begin
          w_state_nxt = RD;
          w_voice_nxt = r_voice + 1'b1;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_voice_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_voice   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_voice   <= w_voice_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NVOICE; i++) r_inc[i] <= '0;
    end else if (bus.inc_we) begin
      r_inc[bus.inc_addr] <= bus.inc_data;
    end
  end

  // The increment is captured here, so a same-edge host write lands one sweep later.
  always_ff @(posedge clk) begin
    if (r_state == RD) begin
      r_ph_lat  <= w_st_rdata;
      r_inc_lat <= r_inc[r_voice];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase_out   <= '0;
      r_phase_voice <= '0;
      r_phase_valid <= 1'b0;
      r_phase_wrap  <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_phase_valid <= w_out_ld;
      r_sweep_done  <= w_done;
      r_overrun     <= w_overrun;
      if (w_out_ld) begin
        r_phase_out   <= w_upd_phase[ACC_W-1 -: OUT_W];
        r_phase_voice <= r_voice;
        r_phase_wrap  <= w_upd_wrap;
      end
    end
  end

  assign bus.phase_out   = r_phase_out;
  assign bus.phase_voice = r_phase_voice;
  assign bus.phase_valid = r_phase_valid;
  assign bus.phase_wrap  = r_phase_wrap;
  assign bus.sweep_done  = r_sweep_done;
  assign bus.overrun     = r_overrun;
  assign bus.busy        = (r_state != IDLE);
endmodule
